// File: rtl/match_event_logger.sv
// Timestamps rising edges of sequence_found and queues them in a FWFT FIFO,
// with a saturating total of detections and a sticky drop flag.
module match_event_logger #(
  parameter int TS_WIDTH  = 16,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sequence_found,
  input  logic                       rd_en,
  output logic                       evt_valid,
  output logic [TS_WIDTH-1:0]        evt_timestamp,
  output logic [$clog2(DEPTH):0]     evt_level,
  output logic [CNT_WIDTH-1:0]       match_total,
  output logic                       overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [TS_WIDTH-1:0] ts;
  logic                sf_q;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [TS_WIDTH-1:0] mem [DEPTH];
  logic                evt, full, empty, do_push, do_pop, drop;
  logic [LW-1:0]       level_nxt;

  // A full FIFO still accepts the event when the head is popped in the same cycle.
  always_comb begin
    evt       = sequence_found & ~sf_q;
    empty     = (evt_level == '0);
    full      = (evt_level == LW'(DEPTH));
    do_pop    = rd_en & ~empty;
    do_push   = evt & (~full | do_pop);
    drop      = evt & full & ~do_pop;
    level_nxt = evt_level;
    if (do_push && !do_pop)
      level_nxt = evt_level + LW'(1);
    else if (do_pop && !do_push)
      level_nxt = evt_level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts          <= '0;
      sf_q        <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      evt_level   <= '0;
      evt_valid   <= 1'b0;
      match_total <= '0;
      overflow    <= 1'b0;
    end else begin
      ts        <= ts + TS_WIDTH'(1);
      sf_q      <= sequence_found;
      evt_level <= level_nxt;
      evt_valid <= (level_nxt != '0);
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (evt && (match_total != '1)) match_total <= match_total + CNT_WIDTH'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage carries no reset; stale contents are masked by evt_valid.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= ts;
  end

  assign evt_timestamp = evt_valid ? mem[rd_ptr] : '0;

endmodule

// File: doc/match_event_logger.md
# match_event_logger

Downstream consumer of the `sequence_detector` `sequence_found` output. Each detection (rising edge of `sequence_found`) is timestamped with a free-running cycle counter and queued in a small first-word-fall-through FIFO for a host or monitor to drain. The block also keeps a saturating total of detections and a sticky overflow flag, so bursts of matches are never silently lost.

## Interface
- `TS_WIDTH`, 16: timestamp counter width; wraps modulo 2^TS_WIDTH.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `CNT_WIDTH`, 8: width of the saturating match total.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sequence_found`  in  1  detector match output, sampled every cycle.
- `rd_en`  in  1  pop request for the head entry; ignored when `evt_valid`=0.
- `evt_valid`  out  1  FIFO non-empty.
- `evt_timestamp`  out  TS_WIDTH  timestamp of head entry; 0 when empty.
- `evt_level`  out  $clog2(DEPTH)+1  current entry count, 0..DEPTH.
- `match_total`  out  CNT_WIDTH  events seen since reset, including dropped; saturates at all-ones.
- `overflow`  out  1  sticky: an event was dropped on a full FIFO.

## Operation
- Reset (sync, `reset`=1 at a rising edge) drives every output and register to 0: `ts`, previous-sample register `sf_q`, write/read pointers, `evt_level`, `evt_valid`, `evt_timestamp`, `match_total`, `overflow`. Reset overrides every other action in the same cycle. Reset asserted mid-operation discards all queued entries.
- Timestamp: `ts` is 0 in the first cycle after reset deasserts and increments by 1 every cycle after that. It wraps from 2^TS_WIDTH−1 to 0 with no flag.
- Event detect: `event = sequence_found & ~sf_q`, where `sf_q` is the value of `sequence_found` registered on the previous cycle.
  - `sf_q` resets to 0, so `sequence_found` high in the first post-reset cycle counts as an event.
  - A level held high for N cycles produces exactly one event.
  - Low-high-low-high produces two events.
- On an event, the entry written is the `ts` value of the cycle in which the event is seen.
- Push/pop rules, evaluated in the same cycle:
  - Event, not full: push. `evt_level` +1 unless a valid pop also occurs.
  - Event, full, `rd_en`=1: pop and push both happen. `evt_level` stays at DEPTH and `overflow` is unchanged.
  - Event, full, `rd_en`=0: the entry is dropped and `overflow` is set to 1. `overflow` clears only on reset.
  - Empty, `rd_en`=1 with an event: push only; the pop is ignored.
  - `rd_en`=1 while empty with no event: no effect.
- `match_total` increments on every event, including dropped ones, and holds at 2^CNT_WIDTH−1.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty status comes from `evt_level`.

## Timing
- `evt_valid`, `evt_level`, `match_total` and `overflow` are registered.
- `evt_timestamp` is a combinational read of the head entry, forced to 0 when empty.
- Latency: an event seen in cycle k is written at the edge ending cycle k. `evt_valid`/`evt_timestamp` reflect it from cycle k+1.
- Pop: `rd_en`=1 with `evt_valid`=1 in cycle k removes the head at the edge ending cycle k. The next entry is visible in cycle k+1. Back-to-back pops every cycle are supported.
- `match_total` and `overflow` update with the same one-cycle latency as the push.
- No combinational path from `sequence_found` or `rd_en` to any output.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with `sequence_found`=1 → `evt_valid`=0, `evt_level`=0, `evt_timestamp`=0, `match_total`=0, `overflow`=0. Release reset with `sequence_found` still 1 → one event at ts=0, and `evt_timestamp`=0 with `evt_valid`=1 in the next cycle.
- Single pulse and hold: 1-cycle pulse at ts=5, then a 4-cycle level starting at ts=10 → exactly 2 entries (5, 10) and `match_total`=2. Draining with `rd_en` yields 5 then 10, then `evt_valid`=0.
- Overflow (`DEPTH`=8): 9 pulses at ts=2,4,…,18 with no reads → `evt_level`=8, `overflow`=1, `match_total`=9, and the drained sequence is 2,4,…,16.
- Simultaneous push and pop on full: FIFO at 8 entries, event at the same cycle as `rd_en`=1 → `evt_level` stays 8, `overflow` stays 0, head advances, and the new timestamp lands at the tail.
- Wrap and saturation (`TS_WIDTH`=4, `CNT_WIDTH`=2): event at cycle 17 after reset → `evt_timestamp`=1. Five events → `match_total`=3.
- Reset mid-operation: 3 entries queued with `overflow`=1, pulse `reset` for 1 cycle → next cycle all outputs are 0, and the first subsequent event is timestamped relative to the new reset.
